// File: rtl/multi_chan_scoreboard.sv
// multi_chan_scoreboard: shadows NCH FIFO occupancies, tags one pushed word and checks it when it is popped
module multi_chan_scoreboard #(
    parameter int NCH   = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CNTW  = $clog2(DEPTH + 1),
    parameter int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 rearm,
    input  logic [NCH-1:0]       push,
    input  logic [NCH-1:0]       pop,
    input  logic [NCH*WIDTH-1:0] data_in,
    input  logic [NCH*WIDTH-1:0] data_out,
    output logic [NCH-1:0]       full,
    output logic [NCH-1:0]       empty,
    output logic                 tracking,
    output logic [CHW-1:0]       track_chan,
    output logic                 data_out_vld,
    output logic                 prop_signal
);
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2;
    localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);
    logic [CNTW-1:0]  cnt [NCH];
    logic [NCH-1:0]   lpush, lpop;
    logic [1:0]       state;
    logic [WIDTH-1:0] tag;
    logic [CNTW-1:0]  ahead;
    logic [CHW-1:0]   sel;
    always_comb begin
        lpop  = '0;
        full  = '0;
        empty = '0;
        for (int i = 0; i < NCH; i++) begin
            lpop[i]  = pop[i] && cnt[i] != '0;
            full[i]  = cnt[i] == DEPTH_C;
            empty[i] = cnt[i] == '0;
        end
    end
    always_comb begin
        lpush = '0;
        for (int i = 0; i < NCH; i++)
            lpush[i] = push[i] && (cnt[i] < DEPTH_C || lpop[i]);
    end
    // descending scan so the lowest pushing channel wins the tag
    always_comb begin
        sel = '0;
        for (int i = NCH - 1; i >= 0; i--)
            if (lpush[i]) sel = CHW'(i);
    end
    assign tracking = state == WAIT;
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
            state        <= IDLE;
            track_chan   <= '0;
            data_out_vld <= 1'b0;
            prop_signal  <= 1'b1;
            tag          <= '0;
            ahead        <= '0;
        end else begin
            for (int i = 0; i < NCH; i++)
                cnt[i] <= cnt[i] + CNTW'(lpush[i]) - CNTW'(lpop[i]);
            data_out_vld <= 1'b0;
            case (state)
                IDLE: if (start && |lpush) begin
                    tag        <= data_in[sel*WIDTH +: WIDTH];
                    track_chan <= sel;
                    ahead      <= cnt[sel] - CNTW'(lpop[sel]);
                    state      <= WAIT;
                end
                WAIT: if (lpop[track_chan]) begin
                    if (ahead != '0) ahead <= ahead - CNTW'(1);
                    else begin
                        data_out_vld <= 1'b1;
                        if (data_out[track_chan*WIDTH +: WIDTH] != tag) prop_signal <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: if (rearm) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multi_chan_scoreboard.sv
// tb_multi_chan_scoreboard: directed self-checking bench for multi_chan_scoreboard
module tb_multi_chan_scoreboard;
    logic        clk = 1'b0;
    logic        rst, start, rearm;
    logic [3:0]  push, pop, full, empty;
    logic [31:0] data_in, data_out;
    logic        tracking, data_out_vld, prop_signal;
    logic [1:0]  track_chan;
    int          errors = 0, checks = 0;

    multi_chan_scoreboard dut (
        .clk(clk), .rst(rst), .start(start), .rearm(rearm), .push(push), .pop(pop),
        .data_in(data_in), .data_out(data_out), .full(full), .empty(empty),
        .tracking(tracking), .track_chan(track_chan), .data_out_vld(data_out_vld),
        .prop_signal(prop_signal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        start = 1'b0; push = '0; pop = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        quiet();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; rearm = 1'b0; data_in = '0; data_out = '0;
        quiet();
        tick(); tick();
        chk("rst_empty", 32'(empty), 32'hF);
        chk("rst_full", 32'(full), 0);
        chk("rst_prop", 32'(prop_signal), 1);
        chk("rst_tracking", 32'(tracking), 0);
        chk("rst_vld", 32'(data_out_vld), 0);
        chk("rst_chan", 32'(track_chan), 0);
        rst = 1'b1;

        // basic: A5, 3C(tagged), 77 on ch2, then pop A5 and 3C
        push = 4'b0100; data_in[16 +: 8] = 8'hA5; tick();
        start = 1'b1; data_in[16 +: 8] = 8'h3C; tick();
        chk("basic_tracking", 32'(tracking), 1);
        chk("basic_chan", 32'(track_chan), 2);
        start = 1'b0; data_in[16 +: 8] = 8'h77; tick();
        chk("basic_empty", 32'(empty), 32'hB);
        push = '0; pop = 4'b0100; data_out[16 +: 8] = 8'hA5; tick();
        chk("basic_vld_early", 32'(data_out_vld), 0);
        chk("basic_still_tracking", 32'(tracking), 1);
        data_out[16 +: 8] = 8'h3C; tick();
        chk("basic_vld", 32'(data_out_vld), 1);
        chk("basic_prop", 32'(prop_signal), 1);
        chk("basic_done", 32'(tracking), 0);
        pop = '0; tick();
        chk("basic_vld_pulse", 32'(data_out_vld), 0);
        chk("basic_empty_after", 32'(empty), 32'hB);

        // corruption: checking pop sees 3D instead of 3C
        do_reset();
        push = 4'b0100; data_in[16 +: 8] = 8'hA5; tick();
        start = 1'b1; data_in[16 +: 8] = 8'h3C; tick();
        start = 1'b0; data_in[16 +: 8] = 8'h77; tick();
        push = '0; pop = 4'b0100; data_out[16 +: 8] = 8'hA5; tick();
        chk("corr_prop_before", 32'(prop_signal), 1);
        data_out[16 +: 8] = 8'h3D; tick();
        chk("corr_vld", 32'(data_out_vld), 1);
        chk("corr_prop", 32'(prop_signal), 0);
        pop = '0; start = 1'b1; push = 4'b0001; tick();
        start = 1'b0; push = '0; tick(); tick();
        chk("corr_sticky", 32'(prop_signal), 0);
        chk("done_ignores_start", 32'(tracking), 0);
        do_reset(); tick();
        chk("corr_reset_prop", 32'(prop_signal), 1);
        chk("corr_reset_empty", 32'(empty), 32'hF);

        // priority: ch1 and ch3 push together, ch1 wins; ch3 pops don't advance the tag
        rearm = 1'b1;
        start = 1'b1; push = 4'b1010; data_in[8 +: 8] = 8'h11; data_in[24 +: 8] = 8'h33; tick();
        chk("prio_chan", 32'(track_chan), 1);
        chk("prio_tracking", 32'(tracking), 1);
        start = 1'b0; push = '0; pop = 4'b1000; data_out[24 +: 8] = 8'h33; tick();
        chk("prio_ch3_pop_vld", 32'(data_out_vld), 0);
        tick();
        chk("prio_ch3_empty", 32'(empty), 32'hD);
        chk("prio_still_tracking", 32'(tracking), 1);
        pop = 4'b0010; data_out[8 +: 8] = 8'h11; tick();
        chk("prio_vld", 32'(data_out_vld), 1);
        chk("prio_prop", 32'(prop_signal), 1);
        pop = '0; tick();

        // boundary: fill ch0, push at full, push+pop at full with tag
        do_reset();
        push = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            data_in[7:0] = 8'(i); tick();
        end
        chk("bnd_full", 32'(full), 1);
        data_in[7:0] = 8'hEE; tick();
        chk("bnd_push_at_full", 32'(full), 1);
        start = 1'b1; pop = 4'b0001; data_in[7:0] = 8'hC8; data_out[7:0] = 8'h00; tick();
        chk("bnd_pushpop_full", 32'(full), 1);
        chk("bnd_tagged", 32'(tracking), 1);
        start = 1'b0; push = '0;
        for (int i = 1; i < 8; i++) begin
            data_out[7:0] = 8'(i); tick();
        end
        chk("bnd_wait_vld", 32'(data_out_vld), 0);
        chk("bnd_wait_tracking", 32'(tracking), 1);
        data_out[7:0] = 8'hC8; tick();
        chk("bnd_vld", 32'(data_out_vld), 1);
        chk("bnd_prop", 32'(prop_signal), 1);
        chk("bnd_drained", 32'(empty), 32'hF);
        tick();
        chk("bnd_pop_empty", 32'(empty), 32'hF);
        pop = '0;

        // rearm: three back-to-back tags on ch0
        do_reset();
        for (int k = 0; k < 3; k++) begin
            start = 1'b1; push = 4'b0001; data_in[7:0] = 8'hD0 + 8'(k); tick();
            chk("rearm_tracking", 32'(tracking), 1);
            start = 1'b0; push = '0; pop = 4'b0001; data_out[7:0] = 8'hD0 + 8'(k); tick();
            chk("rearm_vld", 32'(data_out_vld), 1);
            pop = '0; tick();
        end
        chk("rearm_prop", 32'(prop_signal), 1);
        rearm = 1'b0;
        start = 1'b1; push = 4'b0001; data_in[7:0] = 8'h42; tick();
        start = 1'b0; push = '0; pop = 4'b0001; data_out[7:0] = 8'h42; tick();
        chk("norearm_vld", 32'(data_out_vld), 1);
        pop = '0; start = 1'b1; push = 4'b0001; tick();
        chk("norearm_idle", 32'(tracking), 0);
        start = 1'b0; push = '0; tick();
        chk("norearm_stay", 32'(tracking), 0);

        // reset mid-WAIT drops the tag and all counts
        do_reset(); rearm = 1'b1;
        start = 1'b1; push = 4'b0100; tick();
        start = 1'b0; push = 4'b0010; tick();
        chk("mid_tracking", 32'(tracking), 1);
        quiet(); rst = 1'b0; push = 4'b0001; tick();
        chk("mid_rst_tracking", 32'(tracking), 0);
        chk("mid_rst_empty", 32'(empty), 32'hF);
        rst = 1'b1; push = '0; tick();
        chk("mid_rst_vld", 32'(data_out_vld), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
